// File: rtl/fft32_pkg.sv
// Shared constants, bank-state encoding and address helpers for the
// 32-point radix-2 FFT datapath (framer, core, twiddle ROM).
package fft32_pkg;

    localparam int N     = 32;
    localparam int LOG2N = 5;
    localparam int DW    = 32;

    // Q16.16 unity
    localparam logic [DW-1:0] ONE = 32'h0001_0000;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Single write into a frame bank
    typedef struct packed {
        logic             we;
        logic [LOG2N-1:0] addr;
        logic [DW-1:0]    re;
        logic [DW-1:0]    im;
    } bank_wr_t;

    function automatic logic [LOG2N-1:0] bitrev5(
        input logic [LOG2N-1:0] a
    );
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft32_frame_bank.sv
// One 32-slot complex sample bank: single write port, all slots
// readable in parallel as flat buses.
//
// Ports:
//   clk          rising-edge clock
//   wr           write request (we, addr, re, im)
//   rd_re/rd_im  slot k at [k*DW +: DW]
module fft32_frame_bank
    import fft32_pkg::*;
(
    input  logic            clk,
    input  bank_wr_t        wr,
    output logic [N*DW-1:0] rd_re,
    output logic [N*DW-1:0] rd_im
);

    logic [DW-1:0] mem_re [N];
    logic [DW-1:0] mem_im [N];

    // Sample data is never reset; validity is tracked by the bank state.
    always_ff @(posedge clk) begin
        if (wr.we) begin
            mem_re[wr.addr] <= wr.re;
            mem_im[wr.addr] <= wr.im;
        end
    end

    always_comb begin
        rd_re = '0;
        rd_im = '0;
        for (int k = 0; k < N; k++) begin
            rd_re[k*DW +: DW] = mem_re[k];
            rd_im[k*DW +: DW] = mem_im[k];
        end
    end

endmodule

// File: rtl/fft32_input_framer.sv
// Collects a serial complex sample stream into 32-sample frames in a
// ping-pong buffer and presents each frame as flat parallel buses.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   s_valid/s_ready       sample handshake; s_re/s_im data, s_last frame end
//   frame_valid/ready     frame handshake; frame_re/frame_im slot k at k*DW
//   len_err               one-cycle pulse on a framing error
module fft32_input_framer #(
    parameter int N      = fft32_pkg::N,
    parameter int LOG2N  = fft32_pkg::LOG2N,
    parameter int DW     = fft32_pkg::DW,
    parameter bit BITREV = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    input  logic            s_last,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [N*DW-1:0] frame_re,
    output logic [N*DW-1:0] frame_im,
    output logic            len_err
);

    typedef fft32_pkg::bank_state_t bank_state_t;
    typedef fft32_pkg::bank_wr_t    bank_wr_t;

    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] wr_addr;
    logic             wr_bank;
    logic             rd_bank;
    bank_state_t      bank_st [2];

    logic accept;
    logic consume;
    logic cnt_last;

    bank_wr_t         wr0;
    bank_wr_t         wr1;
    logic [N*DW-1:0]  b0_re;
    logic [N*DW-1:0]  b0_im;
    logic [N*DW-1:0]  b1_re;
    logic [N*DW-1:0]  b1_im;

    // Gating with reset keeps both handshakes quiet during reset.
    assign s_ready     = !reset &&
                         (bank_st[wr_bank] != fft32_pkg::BANK_FULL);
    assign frame_valid = !reset &&
                         (bank_st[rd_bank] == fft32_pkg::BANK_FULL);

    assign accept   = s_valid && s_ready;
    assign consume  = frame_valid && frame_ready;
    assign cnt_last = (wr_cnt == LOG2N'(N-1));
    assign wr_addr  = BITREV ? fft32_pkg::bitrev5(wr_cnt) : wr_cnt;

    always_comb begin
        wr0      = '0;
        wr0.we   = accept && !wr_bank;
        wr0.addr = wr_addr;
        wr0.re   = s_re;
        wr0.im   = s_im;
        wr1      = wr0;
        wr1.we   = accept && wr_bank;
    end

    fft32_frame_bank u_bank0 (
        .clk   (clk),
        .wr    (wr0),
        .rd_re (b0_re),
        .rd_im (b0_im)
    );

    fft32_frame_bank u_bank1 (
        .clk   (clk),
        .wr    (wr1),
        .rd_re (b1_re),
        .rd_im (b1_im)
    );

    // Only a FULL bank is read and only a non-FULL bank is written,
    // so the presented frame stays stable under back-pressure.
    assign frame_re = rd_bank ? b1_re : b0_re;
    assign frame_im = rd_bank ? b1_im : b0_im;

    // accept targets a non-FULL bank, consume a FULL one: when both
    // fire in one cycle they always touch different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_st[0] <= fft32_pkg::BANK_EMPTY;
            bank_st[1] <= fft32_pkg::BANK_EMPTY;
            len_err    <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (consume) begin
                bank_st[rd_bank] <= fft32_pkg::BANK_EMPTY;
                rd_bank          <= ~rd_bank;
            end
            if (accept) begin
                if (cnt_last) begin
                    // A frame always completes at slot 31; a missing
                    // s_last is only flagged.
                    bank_st[wr_bank] <= fft32_pkg::BANK_FULL;
                    wr_bank          <= ~wr_bank;
                    wr_cnt           <= '0;
                    len_err          <= !s_last;
                end else if (s_last) begin
                    // Early end: drop the partial frame, refill same bank.
                    bank_st[wr_bank] <= fft32_pkg::BANK_FILLING;
                    wr_cnt           <= '0;
                    len_err          <= 1'b1;
                end else begin
                    bank_st[wr_bank] <= fft32_pkg::BANK_FILLING;
                    wr_cnt           <= wr_cnt + LOG2N'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fft32_input_framer.sv
// Self-checking bench for fft32_input_framer: directed scenarios plus
// random traffic against a frame-queue reference model.
module tb_fft32_input_framer;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int FW = N*DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_re = '0;
    logic [DW-1:0] s_im = '0;
    logic          s_last = 1'b0;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [FW-1:0] frame_re;
    logic [FW-1:0] frame_im;
    logic          len_err;

    fft32_input_framer #(.BITREV(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_re        (s_re),
        .s_im        (s_im),
        .s_last      (s_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_re    (frame_re),
        .frame_im    (frame_im),
        .len_err     (len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: complete frames awaiting consumption (slot layout)
    // and the partial frame being collected.
    logic [FW-1:0] fq_re [$];
    logic [FW-1:0] fq_im [$];
    logic [FW-1:0] part_re;
    logic [FW-1:0] part_im;
    int            pcnt;
    bit            exp_lerr;
    bit            last_acc;
    int            st_ready_low;
    int            st_fv;
    int            st_lerr;

    // Sample index k lands at slot with its 5 bits mirrored.
    function automatic int rev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((k >> b) & 1) == 1) r += (16 >> b);
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs,
                        input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs == expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [FW-1:0] obs,
                             input logic [FW-1:0] expv);
        int bk;
        bk = 0;
        for (int k = N-1; k >= 0; k--) begin
            if (obs[k*DW +: DW] !== expv[k*DW +: DW]) bk = k;
        end
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s slot %0d observed=%h expected=%h", tag, bk,
                   obs[bk*DW +: DW], expv[bk*DW +: DW]);
        end
    endtask

    task automatic model_clear();
        fq_re.delete();
        fq_im.delete();
        part_re  = '0;
        part_im  = '0;
        pcnt     = 0;
        exp_lerr = 1'b0;
    endtask

    // One clock: drive at negedge, check outputs, advance the model.
    task automatic step(input bit v, input logic [31:0] re,
                        input logic [31:0] im, input bit last,
                        input bit fr);
        bit er;
        bit ev;
        bit acc;
        bit con;
        int r;
        @(negedge clk);
        reset       = 1'b0;
        s_valid     = v;
        s_re        = re;
        s_im        = im;
        s_last      = last;
        frame_ready = fr;
        #1;
        er = fq_re.size() < 2;
        ev = fq_re.size() > 0;
        chk1("s_ready", s_ready, er);
        chk1("frame_valid", frame_valid, ev);
        chk1("len_err", len_err, exp_lerr);
        if (ev) begin
            chk_frame("frame_re", frame_re, fq_re[0]);
            chk_frame("frame_im", frame_im, fq_im[0]);
        end
        if (!s_ready) st_ready_low++;
        if (frame_valid) st_fv++;
        if (len_err) st_lerr++;
        acc = v && er;
        con = ev && fr;
        if (con) begin
            void'(fq_re.pop_front());
            void'(fq_im.pop_front());
        end
        exp_lerr = 1'b0;
        if (acc) begin
            r = rev5(pcnt);
            part_re[r*DW +: DW] = re;
            part_im[r*DW +: DW] = im;
            if (pcnt == N-1) begin
                fq_re.push_back(part_re);
                fq_im.push_back(part_im);
                pcnt     = 0;
                exp_lerr = !last;
            end else if (last) begin
                pcnt     = 0;
                exp_lerr = 1'b1;
            end else begin
                pcnt++;
            end
        end
        last_acc = acc;
    endtask

    task automatic idle(input bit fr);
        step(1'b0, 32'h0, 32'h0, 1'b0, fr);
    endtask

    // Hold a sample until it is accepted, bounded.
    task automatic send(input logic [31:0] re, input logic [31:0] im,
                        input bit last, input bit fr);
        int t;
        t = 0;
        last_acc = 1'b0;
        while (!last_acc && t < 200) begin
            step(1'b1, re, im, last, fr);
            t++;
        end
        if (!last_acc) begin
            n_cmp++;
            n_bad++;
            $error("FAIL send_timeout observed=%0d expected=1", t);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_last      = 1'b0;
        frame_ready = 1'b0;
        #1;
        chk1("rst_s_ready", s_ready, 1'b0);
        chk1("rst_frame_valid", frame_valid, 1'b0);
        model_clear();
    endtask

    initial begin
        logic [31:0] h_re;
        logic [31:0] h_im;
        logic [31:0] first;
        bit          v;
        bit          fr;
        bit          last;

        model_clear();
        do_reset();
        idle(1'b0);
        chk1("post_rst_ready", s_ready, 1'b1);
        chk1("post_rst_lerr", len_err, 1'b0);

        // Single frame, ramp data
        st_lerr = 0;
        for (int k = 0; k < N; k++) begin
            send(32'(k), 32'(-k), k == N-1, 1'b0);
        end
        idle(1'b0);
        chk32("t1_slot1_re", frame_re[1*DW +: DW], 32'd16);
        chk32("t1_slot1_im", frame_im[1*DW +: DW], 32'hFFFF_FFF0);
        chk32("t1_slot16_re", frame_re[16*DW +: DW], 32'd1);
        chk32("t1_slot31_re", frame_re[31*DW +: DW], 32'd31);
        chki("t1_lerr_pulses", st_lerr, 0);

        // Back-pressure: two frames fill both banks
        do_reset();
        for (int i = 0; i < 2*N; i++) begin
            send($urandom, $urandom, (i % N) == N-1, 1'b0);
        end
        h_re = $urandom;
        h_im = $urandom;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, h_re, h_im, 1'b0, 1'b0);
            chk1("t2_held", s_ready, 1'b0);
        end
        step(1'b1, h_re, h_im, 1'b0, 1'b1);
        step(1'b1, h_re, h_im, 1'b0, 1'b0);
        chk1("t2_ready_rise", s_ready, 1'b1);
        chk1("t2_frame_b", frame_valid, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Continuous streaming, downstream always ready
        do_reset();
        st_ready_low = 0;
        st_fv        = 0;
        for (int i = 0; i < 4*N; i++) begin
            step(1'b1, $urandom, $urandom, (i % N) == N-1, 1'b1);
        end
        idle(1'b1);
        chki("t3_ready_low", st_ready_low, 0);
        chki("t3_frame_pulses", st_fv, 4);

        // Early s_last on the 9th sample
        do_reset();
        st_lerr = 0;
        for (int i = 0; i < 9; i++) begin
            send($urandom, $urandom, i == 8, 1'b0);
        end
        first = $urandom;
        send(first, $urandom, 1'b0, 1'b0);
        for (int i = 1; i < N; i++) begin
            send($urandom, $urandom, i == N-1, 1'b0);
        end
        idle(1'b0);
        chk1("t4_fv", frame_valid, 1'b1);
        chk32("t4_slot0", frame_re[0 +: DW], first);
        chki("t4_lerr_pulses", st_lerr, 1);

        // Missing s_last on the 32nd sample
        do_reset();
        st_lerr = 0;
        for (int i = 0; i < N; i++) begin
            send($urandom, $urandom, 1'b0, 1'b0);
        end
        idle(1'b0);
        chki("t5_lerr_first", st_lerr, 1);
        for (int i = 0; i < N; i++) begin
            send($urandom, $urandom, i == N-1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chki("t5_lerr_total", st_lerr, 1);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send($urandom, $urandom, 1'b0, 1'b0);
        end
        do_reset();
        idle(1'b0);
        chk1("t6_ready_after", s_ready, 1'b1);
        for (int i = 0; i < N; i++) begin
            send($urandom, $urandom, i == N-1, 1'b0);
        end
        idle(1'b1);
        idle(1'b0);
        chk1("t6_one_frame", frame_valid, 1'b0);

        // Reset with one bank FULL
        for (int i = 0; i < N; i++) begin
            send($urandom, $urandom, i == N-1, 1'b0);
        end
        idle(1'b0);
        do_reset();
        idle(1'b0);
        chk1("t6_full_cleared", frame_valid, 1'b0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            v    = ($urandom % 4) != 0;
            fr   = ($urandom % 3) == 0;
            last = (pcnt == N-1);
            if (($urandom % 50) == 0) last = !last;
            step(v, $urandom, $urandom, last, fr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
